// File: rtl/and_mux.sv
// Registered mux-based AND: each lane selects 0 or B[i] using A[i] as the select.
// The result and its valid flag pass together through a STAGES-deep pipeline.
module and_mux #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             out_valid
);

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("and_mux: STAGES must be in 1..8");
    end

    // Per-lane 2:1 mux: d0 is tied low, d1 is B[i], and A[i] is the select.
    function automatic logic [WIDTH-1:0] mux_and(input logic [WIDTH-1:0] sel,
                                                 input logic [WIDTH-1:0] d1);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = sel[i] ? d1[i] : 1'b0;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] data_q [STAGES];
    logic [WIDTH-1:0] data_d [STAGES];
    logic             vld_q  [STAGES];
    logic             vld_d  [STAGES];

    always_comb begin
        data_d[0] = mux_and(A, B);
        vld_d[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            data_d[k] = data_q[k-1];
            vld_d[k]  = vld_q[k-1];
        end
    end

    // Data loads every cycle, including cycles with in_valid low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                vld_q[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                vld_q[k]  <= vld_d[k];
            end
        end
    end

    assign S         = data_q[STAGES-1];
    assign out_valid = vld_q[STAGES-1];

endmodule

// File: tb/tb_and_mux.sv
// Directed bench for and_mux: three instances cover the narrow single-stage case,
// the 8-lane case and a 3-stage pipeline.
module tb_and_mux;

    logic clk;
    logic rst_n;

    logic       v1, ov1;
    logic [0:0] A1, B1, S1;
    logic       v8, ov8;
    logic [7:0] A8, B8, S8;
    logic       v3, ov3;
    logic [3:0] A3, B3, S3;

    int checks;
    int failures;

    and_mux #(.WIDTH(1), .STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(A1), .B(B1), .S(S1), .out_valid(ov1)
    );
    and_mux #(.WIDTH(8), .STAGES(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(A8), .B(B8), .S(S8), .out_valid(ov8)
    );
    and_mux #(.WIDTH(4), .STAGES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .A(A3), .B(B3), .S(S3), .out_valid(ov3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v1 = 1'b1; A1 = 1'b1; B1 = 1'b1;
        v8 = 1'b1; A8 = 8'hFF; B8 = 8'hFF;
        v3 = 1'b0; A3 = 4'h0; B3 = 4'h0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (S1 !== 1'b0 || ov1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d S=%b ov=%b expected S=0 ov=0", c, S1, ov1);
            end
            checks++;
            if (S3 !== 4'h0 || ov3 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold3 cyc=%0d S=%h ov=%b expected S=0 ov=0", c, S3, ov3);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (S1 !== 1'b1 || ov1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release S=%b ov=%b expected S=1 ov=1", S1, ov1);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] ab [4];
        logic       exp [4];
        ab[0] = 2'b00; exp[0] = 1'b0;
        ab[1] = 2'b10; exp[1] = 1'b0;
        ab[2] = 2'b01; exp[2] = 1'b0;
        ab[3] = 2'b11; exp[3] = 1'b1;
        v1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            A1 = ab[t][1];
            B1 = ab[t][0];
            for (int c = 0; c < 5; c++) begin
                step();
                checks++;
                if (S1 !== exp[t] || ov1 !== 1'b1) begin
                    failures++;
                    $display("FAIL truth AB=%b cyc=%0d S=%b ov=%b expected S=%b ov=1",
                             ab[t], c, S1, ov1, exp[t]);
                end
            end
        end
    endtask

    task automatic test_lanes();
        logic [7:0] av [3];
        logic [7:0] bv [3];
        logic [7:0] ev [3];
        av[0] = 8'hF0; bv[0] = 8'h3C; ev[0] = 8'h30;
        av[1] = 8'hFF; bv[1] = 8'hA5; ev[1] = 8'hA5;
        av[2] = 8'h00; bv[2] = 8'hFF; ev[2] = 8'h00;
        v8 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            A8 = av[t];
            B8 = bv[t];
            step();
            checks++;
            if (S8 !== ev[t] || ov8 !== 1'b1) begin
                failures++;
                $display("FAIL lanes A=%h B=%h S=%h ov=%b expected S=%h ov=1",
                         av[t], bv[t], S8, ov8, ev[t]);
            end
        end
    endtask

    task automatic flush3();
        v3 = 1'b0; A3 = 4'h0; B3 = 4'h0;
        for (int c = 0; c < 3; c++) step();
    endtask

    task automatic test_back_to_back();
        flush3();
        for (int t = 0; t < 7; t++) begin
            if (t < 4) begin
                v3 = 1'b1; A3 = 4'hF; B3 = 4'(t + 1);
            end else begin
                v3 = 1'b0; A3 = 4'hF; B3 = 4'h0;
            end
            step();
            checks++;
            if (t >= 2 && t < 6) begin
                if (S3 !== 4'(t - 1) || ov3 !== 1'b1) begin
                    failures++;
                    $display("FAIL latency t=%0d S=%h ov=%b expected S=%h ov=1",
                             t, S3, ov3, 4'(t - 1));
                end
            end else begin
                if (S3 !== 4'h0 || ov3 !== 1'b0) begin
                    failures++;
                    $display("FAIL latency_idle t=%0d S=%h ov=%b expected S=0 ov=0", t, S3, ov3);
                end
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic pat [3];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        flush3();
        A3 = 4'h1; B3 = 4'h1;
        for (int t = 0; t < 5; t++) begin
            v3 = (t < 3) ? pat[t] : 1'b0;
            step();
            if (t >= 2) begin
                checks++;
                if (S3 !== 4'h1 || ov3 !== pat[t-2]) begin
                    failures++;
                    $display("FAIL valid_gap t=%0d S=%h ov=%b expected S=1 ov=%b",
                             t, S3, ov3, pat[t-2]);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        flush3();
        A3 = 4'hF;
        v3 = 1'b1; B3 = 4'h5; step();
        v3 = 1'b1; B3 = 4'h6; step();
        checks++;
        if (ov3 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pre ov=%b expected ov=0", ov3);
        end
        v3 = 1'b1; B3 = 4'h7; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (S3 !== 4'h0 || ov3 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_edge S=%h ov=%b expected S=0 ov=0", S3, ov3);
        end
        v3 = 1'b0; A3 = 4'h0; B3 = 4'h0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (S3 !== 4'h0 || ov3 !== 1'b0) begin
                failures++;
                $display("FAIL midrst_drain cyc=%0d S=%h ov=%b expected S=0 ov=0", c, S3, ov3);
            end
        end
        v3 = 1'b1; A3 = 4'hF; B3 = 4'h9;
        step();
        v3 = 1'b0; A3 = 4'h0; B3 = 4'h0;
        step();
        step();
        checks++;
        if (S3 !== 4'h9 || ov3 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_new S=%h ov=%b expected S=9 ov=1", S3, ov3);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        v1 = 1'b0; A1 = 1'b0; B1 = 1'b0;
        v8 = 1'b0; A8 = 8'h00; B8 = 8'h00;
        v3 = 1'b0; A3 = 4'h0; B3 = 4'h0;
        #2;
        test_reset();
        test_truth_table();
        test_lanes();
        test_back_to_back();
        test_valid_gaps();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
